memory_access_unit: RTL and testbench
=====================================

# memory_access_unit

Memory-stage data access controller: consumes the access request held in the execute-to-memory pipeline register, runs a req/ack handshake with data memory, and returns load data to writeback. Drives `m_stall` back to the pipeline register to hold the memory stage until the access completes. Sits between the EX/MEM register outputs and the data memory port.

## Interface
- No parameters. Address and data width fixed at 32 bits.
- `clock` input 1: single clock, all state updates on posedge.
- `reset` input 1: synchronous, active-high.
- `m_mem_read` input 1: load requested by the instruction in the memory stage.
- `m_mem_write` input 1: store requested.
- `m_mem_byte` input 1: byte access (1) or word access (0).
- `m_addr` input 32: byte address, from the ALU result.
- `m_wdata` input 32: store data; bits [7:0] are used for byte stores.
- `m_stall` output 1: hold the memory stage. Combinational from state and inputs.
- `m_rdata` output 32: load result, registered.
- `m_misaligned` output 1: misaligned word access flag. See Configuration.
- `dmem_req` output 1: memory request.
- `dmem_we` output 1: write enable.
- `dmem_addr` output 32: word address, with bits [1:0] forced to 0.
- `dmem_wdata` output 32: write data.
- `dmem_be` output 4: byte enables, little-endian.
- `dmem_ack` input 1: request accepted/completed. Read data is valid in the same cycle.
- `dmem_rdata` input 32: read data.

## Operation
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
- An access exists when `m_mem_read | m_mem_write` is high. If both are high, the access is a write; the read is ignored and `m_rdata` is unchanged.
- **IDLE with access:**
  - `dmem_req` = 1 and `m_stall` = 1.
  - If `dmem_ack` = 1, go to DONE. Otherwise go to WAIT.
- **IDLE without access:** `dmem_req` = 0 and `m_stall` = 0.
- **WAIT:**
  - `dmem_req` = 1 and `m_stall` = 1.
  - Request fields are recomputed from the held inputs every cycle, so they are stable.
  - On `dmem_ack`, go to DONE.
- **DONE:**
  - `dmem_req` = 0 and `m_stall` = 0. The pipeline advances at this edge.
  - Unconditionally go to IDLE. The held instruction is never reissued.
- **Load capture:** on the `dmem_ack` cycle of a read, `m_rdata` is loaded.
  - Word load: `dmem_rdata`.
  - Byte load: lane `dmem_rdata[8*a+7:8*a]` zero-extended, where a = `m_addr[1:0]`.
- **Store:**
  - Word store: `dmem_be` = 4'b1111, `dmem_wdata` = `m_wdata`.
  - Byte store: `dmem_be` = 1 << a, and `dmem_wdata` = `m_wdata[7:0]` replicated into all four lanes.
- **Reset values:**
  - state IDLE, `m_rdata` 0.
  - `m_stall`, `dmem_req`, `dmem_we` and `m_misaligned` are 0 during any cycle in which `reset` is high.
- **Reset mid-access:** the FSM returns to IDLE at the next edge. An ack arriving after reset is ignored, and data memory must tolerate an abandoned request.

## Timing
- Every memory access stalls at least 1 cycle.
- For a given access, stall cycles = number of cycles from first `dmem_req` to `dmem_ack`, inclusive.
- `m_rdata` is valid from the DONE cycle and holds until the next load ack.
- Back-to-back accesses: DONE → IDLE → the next access issues `dmem_req` in the IDLE cycle immediately after DONE. There is no dead cycle beyond DONE.
- `dmem_ack` is sampled only while `dmem_req` = 1. An ack in IDLE without an access, or in DONE, is ignored.

## Configuration
- Macro: `MEM_ALIGN_CHECK_EN`.
- **Defined:** a word access with `m_addr[1:0]` ≠ 0 is misaligned.
  - `dmem_req` is not asserted.
  - `m_misaligned` = 1 combinationally in that cycle.
  - `m_stall` = 0, state stays IDLE, and `m_rdata` is unchanged.
  - Byte accesses are never misaligned.
- **Undefined:** `m_misaligned` is tied to 0. Word accesses ignore `m_addr[1:0]` and use the aligned word.

## Structure
- Package `mem_pkg` holds:
  - the state enum (IDLE, WAIT, DONE);
  - `BE_WORD` = 4'b1111;
  - the byte-lane width constant (8).
- Sub-module `load_store_aligner` (combinational) generates `dmem_be` and `dmem_wdata`, and extracts/extends load data.
- The FSM, `m_rdata` register and alignment check live in `memory_access_unit`.

## Test plan
- **Word load, ack in same cycle:** addr 0x100, `dmem_rdata` 0xDEADBEEF → `m_stall` high for exactly 1 cycle; DONE cycle has `m_rdata` = 0xDEADBEEF; `dmem_addr` = 0x100.
- **Byte load, 3-cycle ack delay:** addr 0x203, rdata 0xAB000000 → `m_stall` high for 4 cycles; `m_rdata` = 0x000000AB; `dmem_addr` = 0x200.
- **Byte store:** addr 0x11, wdata 0x12345678 → `dmem_be` = 4'b0010, `dmem_wdata` = 0x78787878, `dmem_we` = 1; `m_rdata` unchanged.
- **Back-to-back store then load, both acked immediately:** requests issue in cycles 0 and 2; total stall = 2 cycles.
- **Reset asserted in WAIT:** state is IDLE and `dmem_req` = 0 on the next cycle; a late ack produces no `m_rdata` change.
- **With `MEM_ALIGN_CHECK_EN`:** word load at 0x102 → `m_misaligned` = 1, `dmem_req` = 0, `m_stall` = 0. Without the macro: request goes to 0x100.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// mem_pkg
// Shared types and constants for the memory-stage access unit.
// Revision: 1.0
// ============================================================================
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam int         BYTE_W  = 8;

endpackage
`default_nettype wire

// File: rtl/load_store_aligner.sv
`default_nettype none
// ============================================================================
// load_store_aligner
// Byte-lane steering: store byte enables/data and load lane extraction.
// Revision: 1.0
// ============================================================================
module load_store_aligner
    import mem_pkg::*;
(
    input  logic        byte_access,
    input  logic [1:0]  lane,
    input  logic [31:0] store_data,
    input  logic [31:0] load_raw,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [BYTE_W-1:0] load_byte;

    always_comb begin
        case (lane)
            2'd0:    load_byte = load_raw[7:0];
            2'd1:    load_byte = load_raw[15:8];
            2'd2:    load_byte = load_raw[23:16];
            default: load_byte = load_raw[31:24];
        endcase
    end

    // Byte stores replicate the byte so any lane selected by be sees it.
    always_comb begin
        if (byte_access) begin
            be        = 4'b0001 << lane;
            wdata     = {4{store_data[BYTE_W-1:0]}};
            load_data = {24'd0, load_byte};
        end else begin
            be        = BE_WORD;
            wdata     = store_data;
            load_data = load_raw;
        end
    end

endmodule
`default_nettype wire

// File: rtl/memory_access_unit.sv
`default_nettype none
// ============================================================================
// memory_access_unit
// Memory-stage req/ack controller with load capture and stage stall.
// Optional macro MEM_ALIGN_CHECK_EN: blocks and flags misaligned word accesses.
// Revision: 1.0
// ============================================================================
module memory_access_unit
    import mem_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        m_mem_read,
    input  logic        m_mem_write,
    input  logic        m_mem_byte,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    output logic        m_stall,
    output logic [31:0] m_rdata,
    output logic        m_misaligned,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    state_t      state;
    state_t      state_next;
    logic        access;
    logic        misaligned;
    logic        issue;
    logic        load_ack;
    logic [31:0] load_data;

    assign access = m_mem_read | m_mem_write;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = access & ~m_mem_byte & (m_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign issue = access & ~misaligned;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (issue) begin
                    state_next = dmem_ack ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (dmem_ack) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request doubles as the stall; both are forced low while in reset.
    always_comb begin
        dmem_req = 1'b0;
        case (state)
            IDLE:    dmem_req = issue;
            WAIT:    dmem_req = 1'b1;
            default: dmem_req = 1'b0;
        endcase
        if (reset) begin
            dmem_req = 1'b0;
        end
    end

    assign m_stall      = dmem_req;
    assign dmem_we      = dmem_req & m_mem_write;
    assign m_misaligned = misaligned & ~reset;
    assign dmem_addr    = {m_addr[31:2], 2'b00};

    // A simultaneous write wins, so the load is only captured for pure reads.
    assign load_ack = dmem_req & dmem_ack & m_mem_read & ~m_mem_write;

    always_ff @(posedge clock) begin
        if (reset) begin
            m_rdata <= 32'd0;
        end else if (load_ack) begin
            m_rdata <= load_data;
        end
    end

    load_store_aligner u_aligner (
        .byte_access (m_mem_byte),
        .lane        (m_addr[1:0]),
        .store_data  (m_wdata),
        .load_raw    (dmem_rdata),
        .be          (dmem_be),
        .wdata       (dmem_wdata),
        .load_data   (load_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_memory_access_unit.sv
`default_nettype none
// ============================================================================
// tb_memory_access_unit
// Randomized transaction-level bench for memory_access_unit.
// Revision: 1.0
// ============================================================================
module tb_memory_access_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        m_mem_read;
    logic        m_mem_write;
    logic        m_mem_byte;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_stall;
    logic [31:0] m_rdata;
    logic        m_misaligned;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_rdata;

    memory_access_unit dut (
        .clock        (clock),
        .reset        (reset),
        .m_mem_read   (m_mem_read),
        .m_mem_write  (m_mem_write),
        .m_mem_byte   (m_mem_byte),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_stall      (m_stall),
        .m_rdata      (m_rdata),
        .m_misaligned (m_misaligned),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_be      (dmem_be),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_stall"}, {31'd0, m_stall}, 32'd0);
        check({tag, "_req"},   {31'd0, dmem_req}, 32'd0);
        check({tag, "_we"},    {31'd0, dmem_we}, 32'd0);
        check({tag, "_rdata"}, m_rdata, model_rdata);
    endtask

    // One whole transaction: request cycles until ack after 'delay' waits, then DONE.
    task automatic do_access(input logic rd, input logic wr, input logic byt,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rv, input int delay);
        logic [1:0]  a;
        logic        is_mis;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        a = addr[1:0];
`ifdef MEM_ALIGN_CHECK_EN
        is_mis = !byt && (a != 2'd0);
`else
        is_mis = 1'b0;
`endif
        m_mem_read  = rd;
        m_mem_write = wr;
        m_mem_byte  = byt;
        m_addr      = addr;
        m_wdata     = wd;
        if (is_mis) begin
            dmem_ack   = 1'($urandom_range(0, 1));
            dmem_rdata = $urandom;
            settle();
            check("mis_flag",  {31'd0, m_misaligned}, 32'd1);
            check("mis_req",   {31'd0, dmem_req}, 32'd0);
            check("mis_stall", {31'd0, m_stall}, 32'd0);
            next_cycle();
            check("mis_rdata", m_rdata, model_rdata);
            return;
        end
        exp_be = byt ? (4'b0001 << a) : 4'b1111;
        exp_wd = byt ? {4{wd[7:0]}} : wd;
        for (int k = 0; k <= delay; k++) begin
            dmem_ack   = (k == delay);
            dmem_rdata = (k == delay) ? rv : $urandom;
            settle();
            check("req_stall", {31'd0, m_stall}, 32'd1);
            check("req_req",   {31'd0, dmem_req}, 32'd1);
            check("req_we",    {31'd0, dmem_we}, {31'd0, wr});
            check("req_addr",  dmem_addr, {addr[31:2], 2'b00});
            check("req_be",    {28'd0, dmem_be}, {28'd0, exp_be});
            check("req_wdata", dmem_wdata, exp_wd);
            check("req_mis",   {31'd0, m_misaligned}, 32'd0);
            check("req_rdata", m_rdata, model_rdata);
            next_cycle();
        end
        if (rd && !wr) begin
            model_rdata = byt ? ((rv >> (8 * a)) & 32'h0000_00FF) : rv;
        end
        dmem_ack   = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        settle();
        check_quiet("done");
        next_cycle();
    endtask

    task automatic idle_cycle();
        m_mem_read  = 1'b0;
        m_mem_write = 1'b0;
        m_mem_byte  = 1'($urandom_range(0, 1));
        m_addr      = $urandom;
        m_wdata     = $urandom;
        dmem_ack    = 1'($urandom_range(0, 1));
        dmem_rdata  = $urandom;
        settle();
        check_quiet("idle");
        check("idle_mis", {31'd0, m_misaligned}, 32'd0);
        next_cycle();
    endtask

    initial begin
        reset       = 1'b1;
        m_mem_read  = 1'b1;
        m_mem_write = 1'b0;
        m_mem_byte  = 1'b0;
        m_addr      = 32'h0000_0102;
        m_wdata     = 32'd0;
        dmem_ack    = 1'b1;
        dmem_rdata  = 32'hFFFF_FFFF;
        model_rdata = 32'd0;

        next_cycle();
        settle();
        check_quiet("reset");
        check("reset_mis", {31'd0, m_misaligned}, 32'd0);
        next_cycle();
        reset    = 1'b0;
        dmem_ack = 1'b0;

        do_access(1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 0);
        do_access(1'b1, 1'b0, 1'b1, 32'h0000_0203, 32'd0, 32'hAB00_0000, 3);
        do_access(1'b0, 1'b1, 1'b1, 32'h0000_0011, 32'h1234_5678, 32'h5555_5555, 1);
        do_access(1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'hCAFE_F00D, 32'd0, 0);
        do_access(1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'd0, 32'h0BAD_CAFE, 0);
        do_access(1'b1, 1'b1, 1'b0, 32'h0000_0048, 32'h1111_2222, 32'h3333_4444, 1);
        do_access(1'b1, 1'b0, 1'b0, 32'h0000_0102, 32'd0, 32'h7654_3210, 1);
        idle_cycle();

        // Reset while waiting for ack; a late ack must not load data.
        m_mem_read  = 1'b1;
        m_mem_write = 1'b0;
        m_mem_byte  = 1'b0;
        m_addr      = 32'h0000_0300;
        dmem_ack    = 1'b0;
        settle();
        check("rst_issue_req", {31'd0, dmem_req}, 32'd1);
        next_cycle();
        settle();
        check("rst_wait_req", {31'd0, dmem_req}, 32'd1);
        next_cycle();
        reset = 1'b1;
        settle();
        check("rst_hold_req",   {31'd0, dmem_req}, 32'd0);
        check("rst_hold_stall", {31'd0, m_stall}, 32'd0);
        next_cycle();
        reset       = 1'b0;
        m_mem_read  = 1'b0;
        dmem_ack    = 1'b1;
        dmem_rdata  = 32'hFFFF_FFFF;
        model_rdata = 32'd0;
        settle();
        check_quiet("rst_late_ack");
        next_cycle();
        settle();
        check("rst_after_rdata", m_rdata, model_rdata);
        next_cycle();

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle_cycle();
            end else begin
                logic rd;
                logic wr;
                rd = 1'($urandom_range(0, 1));
                wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
                do_access(rd, wr, 1'($urandom_range(0, 1)), $urandom, $urandom,
                          $urandom, int'($urandom_range(0, 3)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
